// File: rtl/psa_pkg.sv
// psa_pkg: shared state encoding and constants for the pattern-search scheduler
package psa_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, LOAD, WAIT, RESP} psa_state_t;
  localparam int PSA_AW = 8;
  localparam logic [31:0] NO_MATCH = '1;
endpackage

// File: rtl/psa_rr_arbiter.sv
// psa_rr_arbiter: round-robin pick of the first request above ptr (wrapping)
// req: request vector; ptr: index of the last winner
// gnt: one-hot grant (all zero when no request); idx: encoded grant index
module psa_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int i);
    return IW'((int'(p) + i) % NREQ);
  endfunction
  // Walk from the farthest offset down so the nearest requester above ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[wrap(ptr, i)]) begin
        gnt = '0;
        gnt[wrap(ptr, i)] = 1'b1;
        idx = wrap(ptr, i);
      end
    end
  end
endmodule

// File: rtl/psa_scheduler.sv
// psa_scheduler: shares one pattern-search engine between NREQ requesters, round-robin
// Clock/reset: CLK100MHZ, reset (async, active-low).
// Requester side: req_valid/req_ready (one-hot accept pulse), packed req_p/pl/b/bl.
// Response side: resp_valid/resp_ready, resp_id, resp_found, resp_hit, resp_err.
// Status: last_cycles (saturating WAIT duration of last completed job), busy.
// Engine side: eng_p/pl/b/bl, eng_start, eng_activate, eng_done, eng_found.
// Optional: define PSA_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module psa_scheduler import psa_pkg::*; #(
  parameter int NREQ = 4,
  parameter int AW = PSA_AW,
  parameter int CW = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     CLK100MHZ,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_p,
  input  logic [NREQ*AW-1:0]       req_pl,
  input  logic [NREQ*AW-1:0]       req_b,
  input  logic [NREQ*AW-1:0]       req_bl,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [AW-1:0]            resp_found,
  output logic                     resp_hit,
  output logic                     resp_err,
  output logic [CW-1:0]            last_cycles,
  output logic                     busy,
  output logic [AW-1:0]            eng_p,
  output logic [AW-1:0]            eng_pl,
  output logic [AW-1:0]            eng_b,
  output logic [AW-1:0]            eng_bl,
  output logic                     eng_start,
  output logic                     eng_activate,
  input  logic                     eng_done,
  input  logic [AW-1:0]            eng_found
);
  localparam int IW = $clog2(NREQ);
  localparam logic [AW-1:0] NM = AW'(NO_MATCH);
  localparam logic [CW-1:0] CMAX = '1;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CW) - 1) begin : g_bad_cfg
    $error("psa_scheduler: parameter out of range");
  end
  psa_state_t state, state_n;
  logic [IW-1:0] ptr, gid, g_idx;
  logic [NREQ-1:0] g_oh;
  logic [AW-1:0] job_p, job_pl, job_b, job_bl;
  logic [CW-1:0] cnt, cnt_inc;
  logic bad, done_ok, abort;
  psa_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(g_oh),
    .idx(g_idx)
  );
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + 1'b1;
  assign bad = job_pl == '0 || job_bl == '0 || job_pl > job_bl;
  // cnt is still zero on the first WAIT cycle, where done may be left over from the previous job.
  assign done_ok = eng_done && cnt != '0;
  assign resp_id = gid;
`ifdef PSA_TIMEOUT_EN
  logic quiesce;
  assign abort = !done_ok && cnt_inc == CW'(TIMEOUT_CYCLES);
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge CLK100MHZ or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = |req_valid ? CHECK : IDLE;
      CHECK: state_n = bad ? RESP : LOAD;
      LOAD:  state_n = WAIT;
      WAIT:  state_n = (done_ok || abort) ? RESP : WAIT;
      RESP:  state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    req_ready = state == IDLE ? g_oh : '0;
    resp_valid = state == RESP;
    busy = state != IDLE;
    eng_activate = state == WAIT;
`ifdef PSA_TIMEOUT_EN
    eng_start = state == LOAD || quiesce;
`else
    eng_start = state == LOAD;
`endif
  end
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      ptr <= IW'(NREQ - 1);
      gid <= '0;
      {job_p, job_pl, job_b, job_bl} <= '0;
      {eng_p, eng_pl, eng_b, eng_bl} <= '0;
      cnt <= '0;
      resp_found <= NM;
      resp_hit <= 1'b0;
      resp_err <= 1'b0;
      last_cycles <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        gid <= g_idx;
        job_p <= req_p[g_idx*AW +: AW];
        job_pl <= req_pl[g_idx*AW +: AW];
        job_b <= req_b[g_idx*AW +: AW];
        job_bl <= req_bl[g_idx*AW +: AW];
      end
      if (state == CHECK && bad) begin
        resp_found <= NM;
        resp_hit <= 1'b0;
        resp_err <= 1'b1;
      end
      if (state == CHECK && !bad) {eng_p, eng_pl, eng_b, eng_bl} <= {job_p, job_pl, job_b, job_bl};
      if (state == LOAD) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt_inc;
        if (done_ok || abort) begin
          resp_found <= done_ok ? eng_found : NM;
          resp_hit <= done_ok && eng_found != NM;
          resp_err <= !done_ok;
          last_cycles <= cnt_inc;
        end
      end
      if (state == RESP && resp_ready) ptr <= gid;
    end
  end
`ifdef PSA_TIMEOUT_EN
  // One extra start pulse right after an abort restarts the engine into a clean state.
  always_ff @(posedge CLK100MHZ or negedge reset)
    if (!reset) quiesce <= 1'b0;
    else quiesce <= state == WAIT && abort;
`endif
endmodule

// File: tb/tb_psa_scheduler.sv
// tb_psa_scheduler: randomized job stream against a transaction-level scheduler model
module tb_psa_scheduler;
  localparam int NREQ = 4;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*AW-1:0] req_p = '0, req_pl = '0, req_b = '0, req_bl = '0;
  logic resp_valid, resp_ready = 1'b0, resp_hit, resp_err, busy;
  logic [1:0] resp_id;
  logic [AW-1:0] resp_found, eng_p, eng_pl, eng_b, eng_bl;
  logic [AW-1:0] eng_found = '0;
  logic [CW-1:0] last_cycles;
  logic eng_start, eng_activate;
  logic eng_done = 1'b0;
  int checks = 0;
  int errors = 0;
  int ptr_m = NREQ - 1;
  logic [CW-1:0] last_m = '0;
  logic [31:0] eng_m = '0;
  int g;
  psa_scheduler #(.NREQ(NREQ), .AW(AW), .CW(CW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_pl(req_pl), .req_b(req_b), .req_bl(req_bl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_found(resp_found), .resp_hit(resp_hit), .resp_err(resp_err),
    .last_cycles(last_cycles), .busy(busy),
    .eng_p(eng_p), .eng_pl(eng_pl), .eng_b(eng_b), .eng_bl(eng_bl),
    .eng_start(eng_start), .eng_activate(eng_activate),
    .eng_done(eng_done), .eng_found(eng_found)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Requester that wins when starting the search just after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] m, input int last);
    int r = last;
    repeat (NREQ) begin
      r = (r == NREQ - 1) ? 0 : r + 1;
      if (m[r]) return r;
    end
    return -1;
  endfunction
  task automatic check_reset();
    check("rst_busy", busy, 0);
    check("rst_rv", resp_valid, 0);
    check("rst_found", resp_found, 8'hFF);
    check("rst_hit_err", {resp_hit, resp_err}, 0);
    check("rst_last", last_cycles, 0);
    check("rst_id", resp_id, 0);
    check("rst_eng", {eng_p, eng_pl, eng_b, eng_bl}, 0);
    check("rst_ctl", {eng_start, eng_activate, req_ready}, 0);
  endtask
  // d: WAIT cycle on which the engine raises done (0 = never); hold: cycles with resp_ready low.
  task automatic run_job(input logic [NREQ-1:0] mask, input bit keep, input logic [7:0] jp, jpl, jb, jbl,
                         input int d, input logic [7:0] fnd, input int hold, output int gw);
    bit bad;
    int starts, st_cyc, rsp_cyc, w, lat;
    logic [7:0] ef;
    logic eh, ee;
    logic [CW-1:0] el;
    @(negedge clk);
    check("idle_busy", busy, 0);
    gw = pick(mask, ptr_m);
    for (int i = 0; i < NREQ; i++) begin
      req_p[i*AW +: AW] = (i == gw) ? jp : 8'($urandom);
      req_pl[i*AW +: AW] = (i == gw) ? jpl : 8'($urandom);
      req_b[i*AW +: AW] = (i == gw) ? jb : 8'($urandom);
      req_bl[i*AW +: AW] = (i == gw) ? jbl : 8'($urandom);
    end
    req_valid = mask;
    #1 check("grant", req_ready, 4'b1 << gw);
    bad = jpl == 0 || jbl == 0 || jpl > jbl;
    starts = 0; st_cyc = -1; rsp_cyc = -1; w = 0;
    for (int c = 1; c <= 300 && rsp_cyc < 0; c++) begin
      @(negedge clk);
      req_valid = keep ? mask : '0;
      if (eng_activate) begin
        w++;
        if (w > 1) eng_done = d != 0 && w >= d;
        if (w == d) eng_found = fnd;
      end
      #1;
      check("no_regrant", req_ready, 0);
      if (eng_start) begin
        starts++;
        if (st_cyc < 0) begin
          st_cyc = c;
          check("eng_fields", {eng_p, eng_pl, eng_b, eng_bl}, {jp, jpl, jb, jbl});
        end
      end
      if (eng_activate) check("eng_hold", {eng_p, eng_pl, eng_b, eng_bl}, {jp, jpl, jb, jbl});
      if (resp_valid) rsp_cyc = c;
    end
    if (bad) begin
      ef = 8'hFF; eh = 0; ee = 1; el = last_m; lat = 2;
      check("starts_bad", starts, 0);
    end else begin
      if (d == 0) begin
        ef = 8'hFF; eh = 0; ee = 1; el = CW'(TO); lat = 3 + TO;
        check("starts_to", starts, 2);
      end else begin
        ef = fnd; eh = fnd != 8'hFF; ee = 0; el = CW'(d); lat = 3 + d;
        check("starts", starts, 1);
      end
      check("start_cyc", st_cyc, 2);
      last_m = el;
      eng_m = {jp, jpl, jb, jbl};
    end
    check("resp_lat", rsp_cyc, lat);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        req_valid = 4'($urandom_range(1, 15));
        #1;
      end
      check("resp_valid", resp_valid, 1);
      check("resp_id", resp_id, gw);
      check("resp_found", resp_found, ef);
      check("resp_hit_err", {resp_hit, resp_err}, {eh, ee});
      check("last_cycles", last_cycles, el);
      check("eng_kept", {eng_p, eng_pl, eng_b, eng_bl}, eng_m);
      check("resp_no_grant", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = '0;
    #1;
    check("resp_drop", resp_valid, 0);
    check("idle_after", busy, 0);
    ptr_m = gw;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1 check_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_job(4'hF, 1, 8'd1, 8'd3, 8'd10, 8'd40, 4 + i, 8'(20 + i), 0, g);
      check("rr_order", g, i % 4);
    end
    run_job(4'b0001, 0, 8'd2, 8'd2, 8'd0, 8'd20, 15, 8'h07, 0, g);
    run_job(4'b0100, 0, 8'd9, 8'd5, 8'd1, 8'd3, 10, 8'h11, 1, g);
    run_job(4'b0010, 0, 8'd4, 8'd3, 8'd50, 8'd60, 7, 8'hFF, 10, g);
    for (int i = 0; i < 25; i++)
      run_job(4'($urandom_range(1, 15)), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 8)), 8'($urandom),
              8'($urandom_range(0, 12)), $urandom_range(2, 20),
              ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254)), $urandom_range(0, 4), g);
`ifdef PSA_TIMEOUT_EN
    run_job(4'b1000, 0, 8'd3, 8'd2, 8'd5, 8'd9, 0, 8'h00, 2, g);
`endif
    @(negedge clk);
    req_pl[AW +: AW] = 8'd2;
    req_bl[AW +: AW] = 8'd9;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    eng_done = 1'b0;
    for (int c = 0; c < 20 && !eng_activate; c++) @(negedge clk);
    check("rst_wait_reached", eng_activate, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = NREQ - 1;
    last_m = '0;
    eng_m = '0;
    run_job(4'hF, 0, 8'd6, 8'd1, 8'd7, 8'd1, 3, 8'h42, 0, g);
    check("after_reset_g", g, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
